// File: rtl/shiftrows_pkg.sv
// Shared definitions for the ShiftRows stream block.
//   state_t  : loader FSM states (LOAD collects columns, HOLD waits on output)
//   nb_legal : true for the Rijndael column counts 4, 6, 8
//   row_off  : cyclic row offset for row r at a given column count
package shiftrows_pkg;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   function automatic bit nb_legal(input int nb);
      return (nb == 4) || (nb == 6) || (nb == 8);
   endfunction

   // NB=4/6 -> 0,1,2,3 ; NB=8 -> 0,1,3,4
   function automatic int unsigned row_off(input int nb, input int unsigned r);
      return ((nb == 8) && (r >= 2)) ? r + 1 : r;
   endfunction

endpackage

// File: rtl/shiftrows_stream_if.sv
// Column-in / block-out stream bundle for shiftrows_stream.
//   in_valid/in_ready/in_col/in_inv/in_last : column beat input (row r at [r*CELL_W +: CELL_W])
//   out_valid/out_ready/out_state/out_inv   : permuted block output (column c at [c*4*CELL_W +: 4*CELL_W])
//   frame_err                               : one-cycle pulse on in_last mismatch
// master = stream source / block sink, slave = the shiftrows block.
interface shiftrows_stream_if #(
   parameter int CELL_W = 8,
   parameter int NB     = 4
);
   logic                     in_valid;
   logic                     in_ready;
   logic [4*CELL_W-1:0]      in_col;
   logic                     in_inv;
   logic                     in_last;
   logic                     out_valid;
   logic                     out_ready;
   logic [4*NB*CELL_W-1:0]   out_state;
   logic                     out_inv;
   logic                     frame_err;

   modport master (
      output in_valid, in_col, in_inv, in_last, out_ready,
      input  in_ready, out_valid, out_state, out_inv, frame_err
   );

   modport slave (
      input  in_valid, in_col, in_inv, in_last, out_ready,
      output in_ready, out_valid, out_state, out_inv, frame_err
   );
endinterface

// File: rtl/shiftrows_perm.sv
// Combinational (Inv)ShiftRows permutation of a full state.
//   state_i : 4 x NB cells, column c at [c*4*CELL_W +: 4*CELL_W], row r inside column
//   inv_i   : 0 = ShiftRows (rotate left by offset), 1 = InvShiftRows
//   state_o : permuted state, same layout
module shiftrows_perm
   import shiftrows_pkg::*;
#(
   parameter int CELL_W = 8,
   parameter int NB     = 4
) (
   input  logic [4*NB*CELL_W-1:0] state_i,
   input  logic                   inv_i,
   output logic [4*NB*CELL_W-1:0] state_o
);

   always_comb begin
      int unsigned src;
      int unsigned off;
      state_o = '0;
      src     = 0;
      off     = 0;
      for (int unsigned c = 0; c < NB; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            off = row_off(NB, r);
            src = inv_i ? (c + NB - off) % NB : (c + off) % NB;
            state_o[(c*4 + r)*CELL_W +: CELL_W] = state_i[(src*4 + r)*CELL_W +: CELL_W];
         end
      end
   end

endmodule

// File: rtl/shiftrows_stream.sv
// Streaming ShiftRows: collects NB column beats, emits the permuted block.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : shiftrows_stream_if slave (column input, block output, frame_err)
// A block whose last beat arrives while the output register is free goes
// straight to the output; otherwise the buffer is held (in_ready=0) until free.
module shiftrows_stream
   import shiftrows_pkg::*;
#(
   parameter int CELL_W = 8,
   parameter int NB     = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   shiftrows_stream_if.slave bus
);

   localparam int COL_W = 4 * CELL_W;
   localparam int ST_W  = NB * COL_W;
   localparam int CNT_W = $clog2(NB);

   if (!nb_legal(NB)) begin : g_nb_illegal
      $error("shiftrows_stream: NB must be 4, 6 or 8");
   end

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ST_W-1:0]     buf_q;
   logic                inv_q;
   logic                out_valid_q;
   logic [ST_W-1:0]     out_state_q;
   logic                out_inv_q;
   logic                frame_err_q;

   logic                beat;
   logic                last_beat;
   logic                out_free;
   logic [ST_W-1:0]     perm_in;
   logic [ST_W-1:0]     perm_out;

   always_comb begin
      beat      = bus.in_valid && (state_q == ST_LOAD);
      last_beat = (cnt_q == CNT_W'(NB - 1));
      out_free  = !out_valid_q || bus.out_ready;
      cnt_d     = cnt_q;
      if (beat) cnt_d = last_beat ? '0 : cnt_q + 1'b1;
      // In LOAD the final column is still on in_col, not yet in the buffer.
      perm_in = buf_q;
      if (state_q == ST_LOAD) perm_in[(NB-1)*COL_W +: COL_W] = bus.in_col;
   end

   shiftrows_perm #(
      .CELL_W (CELL_W),
      .NB     (NB)
   ) u_perm (
      .state_i (perm_in),
      .inv_i   (inv_q),
      .state_o (perm_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_LOAD;
         cnt_q       <= '0;
         buf_q       <= '0;
         inv_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_state_q <= '0;
         out_inv_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         cnt_q       <= cnt_d;
         if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
         case (state_q)
            ST_LOAD: begin
               if (beat) begin
                  buf_q[cnt_q*COL_W +: COL_W] <= bus.in_col;
                  if (cnt_q == '0) inv_q <= bus.in_inv;
                  frame_err_q <= (bus.in_last != last_beat);
                  if (last_beat) begin
                     if (out_free) begin
                        out_state_q <= perm_out;
                        out_inv_q   <= inv_q;
                        out_valid_q <= 1'b1;
                     end else begin
                        state_q <= ST_HOLD;
                     end
                  end
               end
            end
            ST_HOLD: begin
               if (out_free) begin
                  out_state_q <= perm_out;
                  out_inv_q   <= inv_q;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_LOAD;
               end
            end
            default: state_q <= ST_LOAD;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == ST_LOAD);
   assign bus.out_valid = out_valid_q;
   assign bus.out_state = out_state_q;
   assign bus.out_inv   = out_inv_q;
   assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_shiftrows_stream.sv
// Scoreboard bench for shiftrows_stream (NB=4 and NB=8 instances).
module tb_shiftrows_stream;

   localparam logic [127:0] A_IN  = {32'h3052411e, 32'he55db4b8, 32'hf198bfe0, 32'hae1127d4};
   localparam logic [127:0] A_OUT = {32'he598271e, 32'hf11141b8, 32'hae52b4e0, 32'h305dbfd4};

   typedef struct {
      logic [127:0] st;
      logic         inv;
   } exp4_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   shiftrows_stream_if #(.CELL_W(8), .NB(4)) if4 ();
   shiftrows_stream_if #(.CELL_W(8), .NB(8)) if8 ();

   shiftrows_stream #(.CELL_W(8), .NB(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
   shiftrows_stream #(.CELL_W(8), .NB(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

   int n_chk  = 0;
   int n_fail = 0;
   int fe4    = 0;
   exp4_t        q4[$];
   logic [255:0] q8[$];

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Monitors: pop expected block on every output handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         if (if4.frame_err) fe4++;
         if (if4.out_valid && if4.out_ready) begin
            if (q4.size() == 0) begin
               check("out4_unexpected", 256'(1), 256'(0));
            end else begin
               exp4_t e;
               e = q4.pop_front();
               check("out4_state", 256'(if4.out_state), 256'(e.st));
               check("out4_inv", 256'(if4.out_inv), 256'(e.inv));
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && if8.out_valid && if8.out_ready) begin
         if (q8.size() == 0) begin
            check("out8_unexpected", 256'(1), 256'(0));
         end else begin
            logic [255:0] e;
            logic [255:0] a;
            e = q8.pop_front();
            a = if8.out_state;
            check("out8_state", a, e);
            check("out8_col0", 256'(a[31:0]), 256'(32'h34231100));
            check("out8_col7", 256'(a[255:224]), 256'(32'h33221007));
            check("out8_inv", 256'(if8.out_inv), 256'(0));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Returns at posedge+1 of the edge that accepted the driven beat.
   task automatic wait_accept(input bit use8);
      bit acc = 1'b0;
      int g   = 0;
      while (!acc && g < 200) begin
         @(negedge clk);
         acc = use8 ? if8.in_ready : if4.in_ready;
         @(posedge clk);
         #1;
         g++;
      end
      if (!acc) check("accept_timeout", 256'(0), 256'(1));
   endtask

   task automatic send4(input logic [127:0] blk, input logic inv, input int lastpos,
                        input int nbeats, input bit push, input logic [127:0] exp,
                        input bit chk_lat);
      for (int i = 0; i < nbeats; i++) begin
         if4.in_valid = 1'b1;
         if4.in_col   = blk[i*32 +: 32];
         if4.in_inv   = (i == 0) ? inv : ~inv;
         if4.in_last  = (i == lastpos);
         wait_accept(1'b0);
         if (push && i == nbeats - 1) begin
            exp4_t e;
            e.st  = exp;
            e.inv = inv;
            q4.push_back(e);
         end
         check("frame_err", 256'(if4.frame_err), 256'((i == lastpos) != (i == 3)));
      end
      if4.in_valid = 1'b0;
      if4.in_last  = 1'b1;
      if4.in_inv   = 1'($urandom_range(1));
      if4.in_col   = $urandom;
      if (chk_lat) check("latency", 256'(if4.out_valid), 256'(1));
   endtask

   task automatic drain();
      int g = 0;
      while ((q4.size() != 0 || q8.size() != 0) && g < 100) begin
         @(posedge clk);
         g++;
      end
      #1;
      check("drain_q4", 256'(q4.size()), 256'(0));
      check("drain_q8", 256'(q8.size()), 256'(0));
   endtask

   initial begin
      logic [255:0] e8;
      int unsigned off8[4];
      off8[0] = 0; off8[1] = 1; off8[2] = 3; off8[3] = 4;
      if4.in_valid = 1'b0; if4.in_col = '0; if4.in_inv = 1'b0; if4.in_last = 1'b1; if4.out_ready = 1'b1;
      if8.in_valid = 1'b0; if8.in_col = '0; if8.in_inv = 1'b0; if8.in_last = 1'b1; if8.out_ready = 1'b1;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_out_valid", 256'(if4.out_valid), 256'(0));
      check("rst_out_state", 256'(if4.out_state), 256'(0));
      check("rst_out_inv", 256'(if4.out_inv), 256'(0));
      check("rst_frame_err", 256'(if4.frame_err), 256'(0));
      check("rst8_out_valid", 256'(if8.out_valid), 256'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("in_ready_after_rst", 256'(if4.in_ready), 256'(1));
      @(posedge clk); #1;

      // NB=8 forward, in(r,c) = 16r + c
      e8 = '0;
      for (int unsigned c = 0; c < 8; c++)
         for (int unsigned r = 0; r < 4; r++)
            e8[(c*4 + r)*8 +: 8] = 8'(16*r + (c + off8[r]) % 8);
      for (int c = 0; c < 8; c++) begin
         if8.in_valid = 1'b1;
         if8.in_col   = {8'(48 + c), 8'(32 + c), 8'(16 + c), 8'(c)};
         if8.in_inv   = (c != 0);
         if8.in_last  = (c == 7);
         wait_accept(1'b1);
         if (c == 7) q8.push_back(e8);
      end
      if8.in_valid = 1'b0;
      check("latency8", 256'(if8.out_valid), 256'(1));
      drain();

      // forward then inverse, back to back with free output
      send4(A_IN, 1'b0, 3, 4, 1'b1, A_OUT, 1'b1);
      idle(2);
      send4(A_OUT, 1'b1, 3, 4, 1'b1, A_IN, 1'b1);
      send4(A_IN, 1'b0, 3, 4, 1'b1, A_OUT, 1'b1);
      drain();

      // output stalled for 12 cycles across two blocks
      if4.out_ready = 1'b0;
      send4(A_IN, 1'b0, 3, 4, 1'b1, A_OUT, 1'b0);
      send4(A_OUT, 1'b1, 3, 4, 1'b1, A_IN, 1'b0);
      check("hold_in_ready", 256'(if4.in_ready), 256'(0));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stall_valid", 256'(if4.out_valid), 256'(1));
         check("stall_state", 256'(if4.out_state), 256'(A_OUT));
         check("stall_inv", 256'(if4.out_inv), 256'(0));
         @(posedge clk); #1;
      end
      if4.out_ready = 1'b1;
      drain();

      // in_last early on beat 1
      send4(A_IN, 1'b0, 1, 4, 1'b1, A_OUT, 1'b1);
      drain();

      // reset with a partial block loaded
      send4(A_IN, 1'b0, 3, 2, 1'b0, A_OUT, 1'b0);
      rst_n = 1'b0;
      idle(2);
      @(negedge clk);
      check("midrst_out_valid", 256'(if4.out_valid), 256'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_in_ready", 256'(if4.in_ready), 256'(1));
      check("midrst_valid_after", 256'(if4.out_valid), 256'(0));
      @(posedge clk); #1;
      send4(A_OUT, 1'b1, 3, 4, 1'b1, A_IN, 1'b1);
      drain();

      idle(3);
      check("frame_err_cycles", 256'(fe4), 256'(2));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
